// File: rtl/rs_age_wake_if.sv
// rtl/rs_age_wake_if.sv - shared uop types and the dispatch/CDB/issue bundle for the reservation station
package rs_age_wake_pkg;
    localparam int ROB_W  = 4;
    localparam int PHYS_W = 6;
    localparam int FU_NUM = 2;
    localparam int FU_W   = 1;
    localparam int FU_ALU = 0;
    localparam int FU_MEM = 1;

    typedef enum logic [1:0] {
        CLS_ALU = 2'd0,
        CLS_BR  = 2'd1,
        CLS_LD  = 2'd2,
        CLS_ST  = 2'd3
    } uop_class_t;

    typedef struct packed {
        uop_class_t        uop_class;
        logic              uses_rs1;
        logic              uses_rs2;
        logic [PHYS_W-1:0] prs1;
        logic [PHYS_W-1:0] prs2;
        logic              rdy1;
        logic              rdy2;
        logic [ROB_W-1:0]  rob_idx;
        logic              epoch;
        logic [7:0]        bundle;
    } rs_uop_t;

    // Branches share the ALU pipe; loads and stores go to the memory pipe.
    function automatic logic [FU_W-1:0] uop_to_fu(uop_class_t c);
        case (c)
            CLS_LD, CLS_ST: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction
endpackage

interface rs_age_wake_if
    import rs_age_wake_pkg::*;
#(
    parameter int RS_SIZE  = 8,
    parameter int WB_PORTS = 2
);
    localparam int CNT_W = $clog2(RS_SIZE + 1);

    logic                 disp_valid;
    logic                 disp_ready;
    rs_uop_t              disp_uop;
    logic [WB_PORTS-1:0]  wb_valid;
    logic [PHYS_W-1:0]    wb_pd [WB_PORTS];
    logic [FU_NUM-1:0]    issue_valid;
    logic [FU_NUM-1:0]    issue_ready;
    rs_uop_t              issue_uop [FU_NUM];
    logic                 flush_valid;
    logic                 recover_valid;
    logic [ROB_W-1:0]     recover_rob_idx;
    logic [ROB_W-1:0]     rob_head_idx;
    logic [CNT_W-1:0]     count;
    logic                 busy;

    modport slave (
        input  disp_valid, disp_uop, wb_valid, wb_pd, issue_ready,
               flush_valid, recover_valid, recover_rob_idx, rob_head_idx,
        output disp_ready, issue_valid, issue_uop, count, busy
    );

    modport master (
        output disp_valid, disp_uop, wb_valid, wb_pd, issue_ready,
               flush_valid, recover_valid, recover_rob_idx, rob_head_idx,
        input  disp_ready, issue_valid, issue_uop, count, busy
    );
endinterface

// File: rtl/rs_age_wake.sv
// rtl/rs_age_wake.sv - age-ordered multi-wakeup reservation station with branch-recovery squash
// RS_AGE_SELECT_EN: oldest-first select via age matrix; otherwise lowest-index ready entry issues.
module rs_age_wake
    import rs_age_wake_pkg::*;
#(
    parameter int RS_SIZE  = 8,
    parameter int WB_PORTS = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    rs_age_wake_if.slave  bus
);
    localparam int CNT_W = $clog2(RS_SIZE + 1);
    localparam int IDX_W = $clog2(RS_SIZE);

    rs_uop_t            r_entries [RS_SIZE];
    logic [RS_SIZE-1:0] r_valid;
    logic [CNT_W-1:0]   r_count;
`ifdef RS_AGE_SELECT_EN
    logic [RS_SIZE-1:0] r_older [RS_SIZE];
`endif

    logic               w_hold;
    logic [RS_SIZE-1:0] w_ready;
    logic [RS_SIZE-1:0] w_cand [FU_NUM];
    logic [IDX_W-1:0]   w_sel_idx [FU_NUM];
    logic [FU_NUM-1:0]  w_fire;
    logic [RS_SIZE-1:0] w_issue_clr;
    logic [CNT_W-1:0]   w_n_issue;
    logic [ROB_W-1:0]   w_br_dist;
    logic [ROB_W-1:0]   w_dist [RS_SIZE];
    logic [RS_SIZE-1:0] w_squash;
    logic [CNT_W-1:0]   w_n_survive;
    logic [IDX_W-1:0]   w_free_idx;
    logic               w_disp_fire;
    logic [RS_SIZE-1:0] w_new_mask;
    rs_uop_t            w_new_uop;
    logic [RS_SIZE-1:0] w_wake1;
    logic [RS_SIZE-1:0] w_wake2;

    assign w_hold = bus.flush_valid || bus.recover_valid;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w_ready[i] = r_valid[i]
                && (!r_entries[i].uses_rs1 || r_entries[i].rdy1)
                && (!r_entries[i].uses_rs2 || r_entries[i].rdy2);
        end
        for (int f = 0; f < FU_NUM; f++) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                w_cand[f][i] = w_ready[i]
                    && (uop_to_fu(r_entries[i].uop_class) == FU_W'(f));
            end
        end
    end

    always_comb begin
        for (int f = 0; f < FU_NUM; f++) begin
            w_sel_idx[f] = '0;
`ifdef RS_AGE_SELECT_EN
            for (int i = 0; i < RS_SIZE; i++) begin
                if (w_cand[f][i] && ((w_cand[f] & r_older[i]) == '0))
                    w_sel_idx[f] = IDX_W'(i);
            end
`else
            for (int i = RS_SIZE - 1; i >= 0; i--) begin
                if (w_cand[f][i])
                    w_sel_idx[f] = IDX_W'(i);
            end
`endif
        end
    end

    always_comb begin
        bus.issue_valid = '0;
        w_fire          = '0;
        w_issue_clr     = '0;
        w_n_issue       = '0;
        for (int f = 0; f < FU_NUM; f++) begin
            bus.issue_valid[f] = (|w_cand[f]) && !w_hold;
            bus.issue_uop[f]   = r_entries[w_sel_idx[f]];
            w_fire[f]          = bus.issue_valid[f] && bus.issue_ready[f];
            if (w_fire[f])
                w_issue_clr[w_sel_idx[f]] = 1'b1;
            w_n_issue = w_n_issue + CNT_W'(w_fire[f]);
        end
    end

    // Ages are measured from the ROB head so the comparison survives index wrap.
    always_comb begin
        w_br_dist   = bus.recover_rob_idx - bus.rob_head_idx;
        w_squash    = '0;
        w_n_survive = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_dist[i]   = r_entries[i].rob_idx - bus.rob_head_idx;
            w_squash[i] = r_valid[i] && (w_dist[i] > w_br_dist);
            w_n_survive = w_n_survive + CNT_W'(r_valid[i] && !w_squash[i]);
        end
    end

    always_comb begin
        w_free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_valid[i])
                w_free_idx = IDX_W'(i);
        end
    end

    assign bus.disp_ready = (r_count < CNT_W'(RS_SIZE)) && !w_hold;
    assign bus.busy       = (r_count == CNT_W'(RS_SIZE));
    assign bus.count      = r_count;
    assign w_disp_fire    = bus.disp_valid && bus.disp_ready;
    assign w_new_mask     = w_disp_fire ? (RS_SIZE'(1) << w_free_idx) : '0;

    always_comb begin
        w_wake1   = '0;
        w_wake2   = '0;
        w_new_uop = bus.disp_uop;
        for (int p = 0; p < WB_PORTS; p++) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (bus.wb_valid[p] && r_entries[i].uses_rs1 && (r_entries[i].prs1 == bus.wb_pd[p]))
                    w_wake1[i] = 1'b1;
                if (bus.wb_valid[p] && r_entries[i].uses_rs2 && (r_entries[i].prs2 == bus.wb_pd[p]))
                    w_wake2[i] = 1'b1;
            end
            if (bus.wb_valid[p] && bus.disp_uop.uses_rs1 && (bus.disp_uop.prs1 == bus.wb_pd[p]))
                w_new_uop.rdy1 = 1'b1;
            if (bus.wb_valid[p] && bus.disp_uop.uses_rs2 && (bus.disp_uop.prs2 == bus.wb_pd[p]))
                w_new_uop.rdy2 = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_count <= '0;
`ifdef RS_AGE_SELECT_EN
            for (int i = 0; i < RS_SIZE; i++)
                r_older[i] <= '0;
`endif
        end else if (bus.flush_valid) begin
            r_valid <= '0;
            r_count <= '0;
        end else if (bus.recover_valid) begin
            r_valid <= r_valid & ~w_squash;
            r_count <= w_n_survive;
        end else begin
            r_valid <= (r_valid & ~w_issue_clr) | w_new_mask;
            r_count <= r_count + CNT_W'(w_disp_fire) - w_n_issue;
`ifdef RS_AGE_SELECT_EN
            // Stale bits for freed slots are harmless: select only looks at valid candidates.
            if (w_disp_fire) begin
                for (int j = 0; j < RS_SIZE; j++) begin
                    if (IDX_W'(j) == w_free_idx)
                        r_older[j] <= r_valid;
                    else
                        r_older[j][w_free_idx] <= 1'b0;
                end
            end
`endif
        end
    end

    // Wakeups land even in flush/recovery cycles so recovery survivors never miss a CDB tag.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_SIZE; i++) begin
            if (w_new_mask[i]) begin
                r_entries[i] <= w_new_uop;
            end else begin
                if (w_wake1[i])
                    r_entries[i].rdy1 <= 1'b1;
                if (w_wake2[i])
                    r_entries[i].rdy2 <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rs_age_wake.sv
// tb/tb_rs_age_wake.sv - directed self-checking bench for rs_age_wake
module tb_rs_age_wake;
    import rs_age_wake_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rs_age_wake_if #(.RS_SIZE(8), .WB_PORTS(2)) bus ();

    rs_age_wake #(.RS_SIZE(8), .WB_PORTS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic rs_uop_t mk(uop_class_t c, logic u1, logic [5:0] p1, logic r1,
                                   logic u2, logic [5:0] p2, logic r2, logic [3:0] rob);
        rs_uop_t u;
        u           = '0;
        u.uop_class = c;
        u.uses_rs1  = u1;
        u.prs1      = p1;
        u.rdy1      = r1;
        u.uses_rs2  = u2;
        u.prs2      = p2;
        u.rdy2      = r2;
        u.rob_idx   = rob;
        return u;
    endfunction

    task automatic idle();
        bus.disp_valid      = 1'b0;
        bus.disp_uop        = '0;
        bus.wb_valid        = '0;
        bus.wb_pd[0]        = '0;
        bus.wb_pd[1]        = '0;
        bus.issue_ready     = '0;
        bus.flush_valid     = 1'b0;
        bus.recover_valid   = 1'b0;
        bus.recover_rob_idx = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(rs_uop_t u);
        bus.disp_valid = 1'b1;
        bus.disp_uop   = u;
        tick();
        bus.disp_valid = 1'b0;
    endtask

    task automatic do_flush();
        bus.flush_valid = 1'b1;
        tick();
        bus.flush_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        bus.rob_head_idx = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++; if (bus.count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.disp_ready !== 1'b1) begin failures++; $display("FAIL reset_disp_ready got=%0b exp=1", bus.disp_ready); end
        checks++; if (bus.issue_valid !== 2'b00) begin failures++; $display("FAIL reset_issue_valid got=%b exp=00", bus.issue_valid); end
        dispatch(mk(CLS_ALU, 1'b1, 6'd1, 1'b1, 1'b0, 6'd0, 1'b0, 4'd0));
        checks++; if (bus.count !== 4'd1) begin failures++; $display("FAIL prereset_count got=%0d exp=1", bus.count); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.count !== 4'd0) begin failures++; $display("FAIL async_reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.issue_valid !== 2'b00) begin failures++; $display("FAIL async_reset_issue got=%b exp=00", bus.issue_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_alu();
        bus.disp_valid = 1'b1;
        bus.disp_uop   = mk(CLS_ALU, 1'b1, 6'd3, 1'b1, 1'b1, 6'd4, 1'b1, 4'd6);
        #1;
        checks++; if (bus.issue_valid[FU_ALU] !== 1'b0) begin failures++; $display("FAIL single_same_cycle_issue got=%0b exp=0", bus.issue_valid[FU_ALU]); end
        tick();
        bus.disp_valid = 1'b0;
        checks++; if (bus.issue_valid !== 2'b01) begin failures++; $display("FAIL single_issue_valid got=%b exp=01", bus.issue_valid); end
        checks++; if (bus.count !== 4'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", bus.count); end
        checks++; if (bus.issue_uop[FU_ALU].rob_idx !== 4'd6) begin failures++; $display("FAIL single_rob got=%0d exp=6", bus.issue_uop[FU_ALU].rob_idx); end
        bus.issue_ready = 2'b01;
        tick();
        bus.issue_ready = 2'b00;
        checks++; if (bus.count !== 4'd0) begin failures++; $display("FAIL single_count_after got=%0d exp=0", bus.count); end
        checks++; if (bus.issue_valid !== 2'b00) begin failures++; $display("FAIL single_issue_after got=%b exp=00", bus.issue_valid); end
    endtask

    task automatic test_dual_wakeup();
        dispatch(mk(CLS_ALU, 1'b1, 6'd12, 1'b0, 1'b1, 6'd20, 1'b0, 4'd2));
        checks++; if (bus.issue_valid[FU_ALU] !== 1'b0) begin failures++; $display("FAIL dual_waiting got=%0b exp=0", bus.issue_valid[FU_ALU]); end
        bus.wb_valid = 2'b11;
        bus.wb_pd[0] = 6'd12;
        bus.wb_pd[1] = 6'd20;
        #1;
        checks++; if (bus.issue_valid[FU_ALU] !== 1'b0) begin failures++; $display("FAIL dual_same_cycle got=%0b exp=0", bus.issue_valid[FU_ALU]); end
        tick();
        bus.wb_valid = 2'b00;
        checks++; if (bus.issue_valid[FU_ALU] !== 1'b1) begin failures++; $display("FAIL dual_woken got=%0b exp=1", bus.issue_valid[FU_ALU]); end
        checks++; if (bus.issue_uop[FU_ALU].rob_idx !== 4'd2) begin failures++; $display("FAIL dual_rob got=%0d exp=2", bus.issue_uop[FU_ALU].rob_idx); end
        bus.issue_ready = 2'b01;
        tick();
        bus.issue_ready = 2'b00;
        checks++; if (bus.count !== 4'd0) begin failures++; $display("FAIL dual_count got=%0d exp=0", bus.count); end
    endtask

    task automatic test_bypass();
        bus.wb_valid = 2'b10;
        bus.wb_pd[1] = 6'd7;
        dispatch(mk(CLS_ALU, 1'b1, 6'd7, 1'b0, 1'b0, 6'd0, 1'b0, 4'd3));
        bus.wb_valid = 2'b00;
        checks++; if (bus.issue_valid[FU_ALU] !== 1'b1) begin failures++; $display("FAIL bypass_ready got=%0b exp=1", bus.issue_valid[FU_ALU]); end
        checks++; if (bus.issue_uop[FU_ALU].rdy1 !== 1'b1) begin failures++; $display("FAIL bypass_rdy1 got=%0b exp=1", bus.issue_uop[FU_ALU].rdy1); end
        bus.issue_ready = 2'b01;
        tick();
        bus.issue_ready = 2'b00;
        bus.wb_valid = 2'b10;
        bus.wb_pd[1] = 6'd7;
        dispatch(mk(CLS_ALU, 1'b1, 6'd8, 1'b0, 1'b0, 6'd0, 1'b0, 4'd4));
        bus.wb_valid = 2'b00;
        checks++; if (bus.issue_valid[FU_ALU] !== 1'b0) begin failures++; $display("FAIL bypass_wrong_tag got=%0b exp=0", bus.issue_valid[FU_ALU]); end
        checks++; if (bus.count !== 4'd1) begin failures++; $display("FAIL bypass_count got=%0d exp=1", bus.count); end
        do_flush();
        checks++; if (bus.count !== 4'd0) begin failures++; $display("FAIL bypass_flush_count got=%0d exp=0", bus.count); end
    endtask

    task automatic test_age_order();
        logic [3:0] exp_first;
        logic [3:0] exp_second;
`ifdef RS_AGE_SELECT_EN
        exp_first  = 4'd5;
        exp_second = 4'd9;
`else
        exp_first  = 4'd9;
        exp_second = 4'd5;
`endif
        dispatch(mk(CLS_LD,  1'b1, 6'd1,  1'b1, 1'b0, 6'd0, 1'b0, 4'd1));
        dispatch(mk(CLS_LD,  1'b1, 6'd33, 1'b0, 1'b0, 6'd0, 1'b0, 4'd2));
        dispatch(mk(CLS_ST,  1'b1, 6'd33, 1'b0, 1'b0, 6'd0, 1'b0, 4'd3));
        dispatch(mk(CLS_ALU, 1'b1, 6'd2,  1'b1, 1'b0, 6'd0, 1'b0, 4'd5));
        checks++; if (bus.issue_valid[FU_MEM] !== 1'b1 || bus.issue_uop[FU_MEM].rob_idx !== 4'd1) begin failures++; $display("FAIL age_mem_first got=%0b/%0d exp=1/1", bus.issue_valid[FU_MEM], bus.issue_uop[FU_MEM].rob_idx); end
        bus.issue_ready = 2'b10;
        tick();
        bus.issue_ready = 2'b00;
        dispatch(mk(CLS_ALU, 1'b1, 6'd2, 1'b1, 1'b0, 6'd0, 1'b0, 4'd9));
        checks++; if (bus.count !== 4'd4) begin failures++; $display("FAIL age_count got=%0d exp=4", bus.count); end
        checks++; if (bus.issue_valid !== 2'b01) begin failures++; $display("FAIL age_issue_valid got=%b exp=01", bus.issue_valid); end
        checks++; if (bus.issue_uop[FU_ALU].rob_idx !== exp_first) begin failures++; $display("FAIL age_first got=%0d exp=%0d", bus.issue_uop[FU_ALU].rob_idx, exp_first); end
        bus.issue_ready = 2'b01;
        tick();
        checks++; if (bus.issue_uop[FU_ALU].rob_idx !== exp_second) begin failures++; $display("FAIL age_second got=%0d exp=%0d", bus.issue_uop[FU_ALU].rob_idx, exp_second); end
        tick();
        bus.issue_ready = 2'b00;
        checks++; if (bus.count !== 4'd2 || bus.issue_valid !== 2'b00) begin failures++; $display("FAIL age_drain got=%0d/%b exp=2/00", bus.count, bus.issue_valid); end
        do_flush();
    endtask

    task automatic test_recovery_wrap();
        bus.rob_head_idx = 4'd14;
        dispatch(mk(CLS_ALU, 1'b1, 6'd1, 1'b1, 1'b0, 6'd0, 1'b0, 4'd15));
        dispatch(mk(CLS_ALU, 1'b1, 6'd1, 1'b1, 1'b0, 6'd0, 1'b0, 4'd1));
        dispatch(mk(CLS_ALU, 1'b1, 6'd1, 1'b1, 1'b0, 6'd0, 1'b0, 4'd3));
        checks++; if (bus.count !== 4'd3 || bus.issue_valid[FU_ALU] !== 1'b1) begin failures++; $display("FAIL recov_setup got=%0d/%0b exp=3/1", bus.count, bus.issue_valid[FU_ALU]); end
        bus.recover_valid   = 1'b1;
        bus.recover_rob_idx = 4'd1;
        bus.disp_valid      = 1'b1;
        bus.disp_uop        = mk(CLS_ALU, 1'b1, 6'd1, 1'b1, 1'b0, 6'd0, 1'b0, 4'd7);
        bus.issue_ready     = 2'b01;
        #1;
        checks++; if (bus.issue_valid !== 2'b00) begin failures++; $display("FAIL recov_issue_valid got=%b exp=00", bus.issue_valid); end
        checks++; if (bus.disp_ready !== 1'b0) begin failures++; $display("FAIL recov_disp_ready got=%0b exp=0", bus.disp_ready); end
        tick();
        idle();
        checks++; if (bus.count !== 4'd2) begin failures++; $display("FAIL recov_count got=%0d exp=2", bus.count); end
        bus.issue_ready = 2'b01;
        #1;
        checks++; if (bus.issue_uop[FU_ALU].rob_idx !== 4'd15) begin failures++; $display("FAIL recov_first got=%0d exp=15", bus.issue_uop[FU_ALU].rob_idx); end
        tick();
        checks++; if (bus.issue_uop[FU_ALU].rob_idx !== 4'd1) begin failures++; $display("FAIL recov_second got=%0d exp=1", bus.issue_uop[FU_ALU].rob_idx); end
        tick();
        bus.issue_ready = 2'b00;
        checks++; if (bus.count !== 4'd0 || bus.issue_valid !== 2'b00) begin failures++; $display("FAIL recov_drain got=%0d/%b exp=0/00", bus.count, bus.issue_valid); end
        bus.rob_head_idx = 4'd0;
    endtask

    task automatic test_full_flush();
        for (int i = 0; i < 8; i++)
            dispatch(mk(CLS_ALU, 1'b1, 6'd1, 1'b1, 1'b0, 6'd0, 1'b0, 4'(i)));
        checks++; if (bus.count !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", bus.count); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL full_busy got=%0b exp=1", bus.busy); end
        checks++; if (bus.disp_ready !== 1'b0) begin failures++; $display("FAIL full_disp_ready got=%0b exp=0", bus.disp_ready); end
        bus.issue_ready = 2'b01;
        dispatch(mk(CLS_ALU, 1'b1, 6'd1, 1'b1, 1'b0, 6'd0, 1'b0, 4'd12));
        bus.issue_ready = 2'b00;
        checks++; if (bus.count !== 4'd7 || bus.busy !== 1'b0) begin failures++; $display("FAIL full_issue_no_free got=%0d/%0b exp=7/0", bus.count, bus.busy); end
        dispatch(mk(CLS_ALU, 1'b1, 6'd1, 1'b1, 1'b0, 6'd0, 1'b0, 4'd13));
        checks++; if (bus.count !== 4'd8) begin failures++; $display("FAIL full_refill got=%0d exp=8", bus.count); end
        bus.flush_valid = 1'b1;
        bus.issue_ready = 2'b11;
        #1;
        checks++; if (bus.issue_valid !== 2'b00) begin failures++; $display("FAIL flush_issue_valid got=%b exp=00", bus.issue_valid); end
        tick();
        idle();
        #1;
        checks++; if (bus.count !== 4'd0 || bus.busy !== 1'b0) begin failures++; $display("FAIL flush_count got=%0d/%0b exp=0/0", bus.count, bus.busy); end
        checks++; if (bus.disp_ready !== 1'b1 || bus.issue_valid !== 2'b00) begin failures++; $display("FAIL flush_after got=%0b/%b exp=1/00", bus.disp_ready, bus.issue_valid); end
    endtask

    task automatic test_back_to_back();
        bus.issue_ready = 2'b11;
        dispatch(mk(CLS_ALU, 1'b1, 6'd1, 1'b1, 1'b0, 6'd0, 1'b0, 4'd4));
        checks++; if (bus.issue_valid !== 2'b01) begin failures++; $display("FAIL b2b_first got=%b exp=01", bus.issue_valid); end
        dispatch(mk(CLS_LD, 1'b1, 6'd1, 1'b1, 1'b0, 6'd0, 1'b0, 4'd5));
        checks++; if (bus.count !== 4'd1 || bus.issue_valid !== 2'b10) begin failures++; $display("FAIL b2b_second got=%0d/%b exp=1/10", bus.count, bus.issue_valid); end
        checks++; if (bus.issue_uop[FU_MEM].rob_idx !== 4'd5) begin failures++; $display("FAIL b2b_mem_rob got=%0d exp=5", bus.issue_uop[FU_MEM].rob_idx); end
        tick();
        bus.issue_ready = 2'b00;
        checks++; if (bus.count !== 4'd0 || bus.issue_valid !== 2'b00) begin failures++; $display("FAIL b2b_drain got=%0d/%b exp=0/00", bus.count, bus.issue_valid); end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_dual_wakeup();
        test_bypass();
        test_age_order();
        test_recovery_wrap();
        test_full_flush();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rs_age_wake.md
# rs_age_wake

Age-ordered, multi-wakeup reservation station holding renamed uops between the rename/dispatch stage and the functional units. It accepts one uop per cycle and snoops `WB_PORTS` CDB writeback ports for operand wakeup. Per functional-unit class it issues the oldest ready entry, and on branch recovery it squashes only entries younger than the mispredicting instruction. It also drives occupancy status back to dispatch.

## Interface
Parameters:
- `RS_SIZE`, 8, number of entries (≥2).
- `WB_PORTS`, 2, number of CDB wakeup ports.
- `CNT_W`, `$clog2(RS_SIZE+1)`, occupancy counter width (derived, not overridden).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `disp_valid` in 1: dispatch request.
- `disp_ready` out 1: entry available and no flush or recovery this cycle.
- `disp_uop` in `rs_uop_t`: uop with `prs1`/`prs2`/`rdy1`/`rdy2`/`rob_idx`/`epoch`/`bundle`.
- `wb_valid` in `[WB_PORTS]`: CDB writeback valid per port.
- `wb_pd` in `[WB_PORTS][PHYS_W]`: CDB destination physical tag per port.
- `issue_valid` out `[FU_NUM]`: a ready entry is offered to FU class f.
- `issue_ready` in `[FU_NUM]`: FU class f accepts.
- `issue_uop` out `rs_uop_t [FU_NUM]`: offered entry per FU class.
- `flush_valid` in 1: kill all entries.
- `recover_valid` in 1: branch recovery.
- `recover_rob_idx` in `ROB_W`: ROB index of the mispredicting branch.
- `rob_head_idx` in `ROB_W`: current ROB head, used for age distance.
- `count` out `CNT_W`: number of valid entries.
- `busy` out 1: RS full (`count == RS_SIZE`).

## Operation
- **Storage.** `entries[RS_SIZE]`, `valid[RS_SIZE]`, and age matrix `older[i][j]` (1 means j is older than i).
- **Priority per cycle.**
  - `flush_valid` has highest priority: clear all `valid`.
  - Otherwise `recover_valid`: clear `valid[i]` where `(entries[i].rob_idx - rob_head_idx) mod 2^ROB_W` > `(recover_rob_idx - rob_head_idx) mod 2^ROB_W`. Entries at or older than the branch survive.
  - Otherwise normal operation: wakeup, dispatch and issue all occur in the same cycle.
- **Wakeup.**
  - For every valid entry, every port p with `wb_valid[p]` and `uses_rs1 && prs1 == wb_pd[p]` sets `rdy1`; likewise for `rs2`.
  - Multiple ports matching the same entry is legal.
- **Dispatch.**
  - Accepted when `disp_valid && disp_ready`. Written into the lowest-index free slot.
  - A source in `disp_uop` matching any valid wb port in the same cycle is stored with its ready bit set (dispatch bypass).
  - Age row for the new slot: `older[new][j] = valid[j]` for all j ≠ new. Column `older[j][new]` is cleared.
- **Ready.** `ready[i] = valid[i] && (!uses_rs1 || rdy1) && (!uses_rs2 || rdy2)`.
- **Select for FU class f.**
  - Candidates: `ready[i] && uop_to_fu(uop_class) == f`.
  - The chosen entry is the candidate i with no candidate j where `older[i][j]`.
  - Exactly one entry is chosen per class; classes are disjoint.
- **Issue.**
  - `issue_valid[f] = 1` iff a candidate exists and there is no flush or recovery this cycle.
  - `issue_valid[f] && issue_ready[f]` clears that entry's `valid` at the clock edge.
  - `issue_uop[f]` is undefined when `issue_valid[f]` is 0.
- **Full/empty.**
  - `disp_ready = (count < RS_SIZE) && !flush_valid && !recover_valid`.
  - An issue in the same cycle does not free a slot for dispatch in that cycle.
- **Counting.** `count` updates as (+1 dispatch) − (number of issues), or to the post-squash popcount on recovery, or to 0 on flush.

## Timing
- **Reset state.** `valid` = 0, `issue_valid` = 0, `count` = 0, `busy` = 0, `disp_ready` = 1 once reset is released. An async assert mid-operation drops all entries immediately.
- **Latencies.**
  - Dispatch to earliest issue: 1 cycle (entry visible the cycle after acceptance).
  - Wakeup to issue: a CDB tag in cycle N makes the entry issuable in cycle N+1.
- **Outputs.** `issue_*`, `disp_ready`, `busy` and `count` are combinational from registered state plus `flush_valid`/`recover_valid`. No input-to-output path exists from `issue_ready`.
- **Recovery.** Takes effect in one cycle. A dispatch offered during recovery is not accepted and must be held by the producer.

## Configuration
- **`RS_AGE_SELECT_EN` defined:** age matrix present; selection is oldest-first as above.
- **Not defined:** no age matrix; selection is lowest-index ready candidate. All other behaviour is identical.

## Test plan
- **Reset then single ALU uop:** dispatch ALU uop with `rdy1`=`rdy2`=1 in cycle 0 → `issue_valid[ALU]` = 1 in cycle 1, `count` = 1. Accept → `count` = 0 in cycle 2.
- **Dual-port wakeup:** entry waiting on `prs1` = 12 and `prs2` = 20; `wb_pd[0]` = 12 and `wb_pd[1]` = 20 in the same cycle → issued the next cycle.
- **Dispatch bypass:** dispatch a uop with `prs1` = 7 not ready while `wb_pd[1]` = 7 is valid → issuable the next cycle, with no further wakeup.
- **Age order (macro on):** fill slots so the uop with `rob_idx` = 5 sits in slot 3 and the one with `rob_idx` = 9 sits in slot 0, both ready for the same FU → slot 3 issues first.
- **Recovery with wrap:** `ROB_W` = 4, `rob_head_idx` = 14, entries `rob_idx` = 15, 1, 3, `recover_rob_idx` = 1 → only the `rob_idx` = 3 entry is killed; `count` drops by 1; `issue_valid` = 0 in the recovery cycle.
- **Full with flush:** fill 8 entries → `busy` = 1, `disp_ready` = 0. Assert `flush_valid` together with `issue_ready` → `count` = 0 next cycle, and no issue handshake completes.
